uart_rx_mmio: RTL and testbench

- Memory-mapped UART receiver peripheral; the serial-in counterpart of the core's UART transmit path.
- Samples the rxd pin, deframes 8N1 characters and buffers them in a small FIFO.
- The core reads status and data through the same single-cycle bus used for the TX registers (base 0x3000_0000, RX window at offset 0x10).
- Raises int_o while data is waiting.

---
 rtl/uart_rx_mmio_pkg.sv | 42 ++++
 rtl/uart_rx_mmio_rx_fifo.sv | 46 ++++
 rtl/uart_rx_mmio.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// STATUS/CTRL bit positions, FSM encodings and the address decode helper.
package uart_rx_mmio_pkg;

  localparam logic [31:0] RxBaseAddr = 32'h3000_0010;

  localparam logic [3:0] RxCtrlOffset   = 4'h0;
  localparam logic [3:0] RxStatusOffset = 4'h4;
  localparam logic [3:0] RxDivOffset    = 4'h8;
  localparam logic [3:0] RxDataOffset   = 4'hC;

  localparam int CtrlRxEn   = 0;
  localparam int CtrlParEn  = 1;
  localparam int CtrlParOdd = 2;

  localparam int StNotEmpty  = 0;
  localparam int StOverrun   = 1;
  localparam int StFrameErr  = 2;
  localparam int StFull      = 3;
  localparam int StCountLsb  = 4;
  // Bit 4 already carries the fill-count LSB, so parity_err sits just above the count field.
  localparam int StParityErr = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  typedef struct packed {
    rx_state_e  state;
    logic [2:0] bit_idx;
    logic       rxd_sync;
  } rx_dbg_t;

  function automatic logic [3:0] reg_sel(input logic [31:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_rx_mmio_rx_fifo.sv
// Synchronous receive FIFO; a pop and a push in the same cycle on a full FIFO
// both succeed (the pop frees the slot the push lands in).
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 434,
  parameter int DIV_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        rxd_i,
  output logic        int_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus handshake: req_i is a one-cycle strobe; writes commit and DATA reads
  // pop on the clk edge that ends the strobe cycle; data_o is valid during it.
  logic [3:0] sel;
  logic       wr_ctrl, wr_status, wr_div, rd_data;
  logic       unused_bus_bits;

  assign sel             = reg_sel(addr_i);
  assign wr_ctrl         = req_i & we_i & (sel == RxCtrlOffset);
  assign wr_status       = req_i & we_i & (sel == RxStatusOffset);
  assign wr_div          = req_i & we_i & (sel == RxDivOffset);
  assign rd_data         = req_i & ~we_i & (sel == RxDataOffset);
  assign unused_bus_bits = ^{addr_i, data_i};

  logic             rx_en;
  logic [DIV_W-1:0] div;
  logic             overrun, frame_err, parity_err;
  logic             par_en, par_odd;

  logic             rxd_s1, rxd_s2;
  rx_state_e        state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_act, div_act_n;
  logic [2:0]       bit_idx, idx_n;
  logic [7:0]       shreg, sh_n;
  logic             par_bad, par_bad_n;
  logic             par_en_act, par_en_act_n;
  logic             par_odd_act, par_odd_act_n;
  logic             push, frame_set, par_set;
  rx_dbg_t          dbg;

  logic [7:0]       fifo_head;
  logic             fifo_empty, fifo_full, pop;
  logic [CW-1:0]    fifo_count;

  assign pop   = rd_data & ~fifo_empty;
  assign int_o = rx_en & ~fifo_empty;
  assign dbg   = '{state: state, bit_idx: bit_idx, rxd_sync: rxd_s2};

  rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        par_en  <= data_i[CtrlParEn];
        par_odd <= data_i[CtrlParOdd];
      end
      parity_err <= (parity_err & ~(wr_status & data_i[StParityErr])) | par_set;
    end
  end
`else
  assign par_en     = 1'b0;
  assign par_odd    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_en     <= 1'b0;
      div       <= DIV_W'(DIV_RESET);
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_ctrl) rx_en <= data_i[CtrlRxEn];
      if (wr_div)  div   <= data_i[DIV_W-1:0];
      // Set wins over a coincident write-one-to-clear.
      overrun   <= (overrun & ~(wr_status & data_i[StOverrun]))
                   | (push & fifo_full & ~pop);
      frame_err <= (frame_err & ~(wr_status & data_i[StFrameErr])) | frame_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1      <= 1'b1;
      rxd_s2      <= 1'b1;
      state       <= ST_IDLE;
      cnt         <= '0;
      div_act     <= DIV_W'(DIV_RESET);
      bit_idx     <= '0;
      shreg       <= '0;
      par_bad     <= 1'b0;
      par_en_act  <= 1'b0;
      par_odd_act <= 1'b0;
    end else begin
      rxd_s1      <= rxd_i;
      rxd_s2      <= rxd_s1;
      state       <= state_n;
      cnt         <= cnt_n;
      div_act     <= div_act_n;
      bit_idx     <= idx_n;
      shreg       <= sh_n;
      par_bad     <= par_bad_n;
      par_en_act  <= par_en_act_n;
      par_odd_act <= par_odd_act_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    div_act_n     = div_act;
    idx_n         = bit_idx;
    sh_n          = shreg;
    par_bad_n     = par_bad;
    par_en_act_n  = par_en_act;
    par_odd_act_n = par_odd_act;
    push          = 1'b0;
    frame_set     = 1'b0;
    par_set       = 1'b0;
    case (state)
      ST_IDLE: begin
        // Divisor and framing options are frozen for the whole frame here.
        if (rx_en && !rxd_s2) begin
          cnt_n         = div >> 1;
          div_act_n     = div;
          par_en_act_n  = par_en;
          par_odd_act_n = par_odd;
          par_bad_n     = 1'b0;
          state_n       = ST_START;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (!rxd_s2) begin
            cnt_n   = div_act;
            idx_n   = '0;
            state_n = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          sh_n  = {rxd_s2, shreg[7:1]};
          cnt_n = div_act;
          idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = par_en_act ? ST_PARITY : ST_STOP;
`else
            state_n = ST_STOP;
`endif
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt == '0) begin
          if (rxd_s2 != ((^shreg) ^ par_odd_act)) begin
            par_bad_n = 1'b1;
            par_set   = 1'b1;
          end
          cnt_n   = div_act;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == '0) begin
          if (rxd_s2) push = ~par_bad;
          else        frame_set = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    data_o = '0;
    case (sel)
      RxCtrlOffset: begin
        data_o[CtrlRxEn]   = rx_en;
        data_o[CtrlParEn]  = par_en;
        data_o[CtrlParOdd] = par_odd;
      end
      RxStatusOffset: begin
        data_o[StNotEmpty]              = ~fifo_empty;
        data_o[StOverrun]               = overrun;
        data_o[StFrameErr]              = frame_err;
        data_o[StFull]                  = fifo_full;
        data_o[StCountLsb+3:StCountLsb] = 4'(fifo_count);
        data_o[StParityErr]             = parity_err;
      end
      RxDivOffset:  data_o[DIV_W-1:0] = div;
      RxDataOffset: data_o[7:0]       = fifo_empty ? 8'h00 : fifo_head;
      default:      data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed testbench for uart_rx_mmio: register access, framing, FIFO
// overrun, glitch rejection, reset mid-frame and optional parity.
module tb_uart_rx_mmio;

  localparam logic [31:0] BASE = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        rxd_i = 1'b1;
  logic        int_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_mmio #(.FIFO_DEPTH(4), .DIV_RESET(434), .DIV_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .rxd_i  (rxd_i),
    .int_o  (int_o)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = BASE | {28'h0, off}; data_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; data_i = '0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE | {28'h0, off};
    #1 d = data_o;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic hold_bit(input logic v, input int clocks);
    rxd_i = v;
    repeat (clocks) @(negedge clk);
  endtask

  // 16-clock bits (div = 15); a low stop bit is shortened so the line is
  // back high well before the receiver's next start check.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    hold_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_bit(b[i], 16);
    hold_bit(stop, stop ? 16 : 12);
    hold_bit(1'b1, 24);
  endtask

  task automatic send_par(input logic [7:0] b, input logic p);
    @(negedge clk);
    hold_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_bit(b[i], 16);
    hold_bit(p, 16);
    hold_bit(1'b1, 16);
    hold_bit(1'b1, 24);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b exp 0", int_o); end
    bus_read(4'h0, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 00000000", r); end
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h exp 00000000", r); end
    bus_read(4'h8, r);
    n_checks++;
    if (r !== 32'd434) begin n_fail++; $display("FAIL reset_div got %h exp 000001b2", r); end
    bus_read(4'hC, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 00000000", r); end
  endtask

  task automatic test_disabled();
    logic [31:0] r;
    bus_write(4'h8, 32'd15);
    send_byte(8'h99, 1'b1);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL disabled_status got %h exp 00000000", r); end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    bus_write(4'h0, 32'h1);
    send_byte(8'hA5, 1'b1);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h11) begin n_fail++; $display("FAIL basic_status got %h exp 00000011", r); end
    n_checks++;
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL basic_int got %b exp 1", int_o); end
    bus_read(4'hC, r);
    n_checks++;
    if (r !== 32'hA5) begin n_fail++; $display("FAIL basic_data got %h exp 000000a5", r); end
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL basic_status_after got %h exp 00000000", r); end
    n_checks++;
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_int_after got %b exp 0", int_o); end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    logic [31:0] exp_q[$];
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    exp_q = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h00};
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h4B) begin n_fail++; $display("FAIL ovr_status got %h exp 0000004b", r); end
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      bus_read(4'hC, r);
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL ovr_data got %h exp %h", r, e); end
    end
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h02) begin n_fail++; $display("FAIL ovr_sticky got %h exp 00000002", r); end
    bus_write(4'h4, 32'h2);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL ovr_w1c got %h exp 00000000", r); end
  endtask

  task automatic test_frame_err();
    logic [31:0] r;
    send_byte(8'h3C, 1'b0);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h04) begin n_fail++; $display("FAIL ferr_status got %h exp 00000004", r); end
    send_byte(8'h3C, 1'b1);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h15) begin n_fail++; $display("FAIL ferr_good_status got %h exp 00000015", r); end
    bus_read(4'hC, r);
    n_checks++;
    if (r !== 32'h3C) begin n_fail++; $display("FAIL ferr_good_data got %h exp 0000003c", r); end
    bus_write(4'h4, 32'h4);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL ferr_w1c got %h exp 00000000", r); end
  endtask

  task automatic test_glitch();
    logic [31:0] r;
    @(negedge clk);
    hold_bit(1'b0, 4);
    hold_bit(1'b1, 40);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL glitch_status got %h exp 00000000", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    @(negedge clk);
    hold_bit(1'b0, 16);
    hold_bit(1'b1, 16);
    hold_bit(1'b0, 8);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rxd_i = 1'b1;
    rst = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(4'h8, r);
    n_checks++;
    if (r !== 32'd434) begin n_fail++; $display("FAIL rst_div got %h exp 000001b2", r); end
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rst_status got %h exp 00000000", r); end
    bus_write(4'h8, 32'd15);
    bus_write(4'h0, 32'h1);
    send_byte(8'h5A, 1'b1);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h11) begin n_fail++; $display("FAIL rst_new_status got %h exp 00000011", r); end
    bus_read(4'hC, r);
    n_checks++;
    if (r !== 32'h5A) begin n_fail++; $display("FAIL rst_new_data got %h exp 0000005a", r); end
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rst_drained got %h exp 00000000", r); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] r;
    bus_write(4'h0, 32'h3);
    send_par(8'h07, 1'b0);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h100) begin n_fail++; $display("FAIL par_bad_status got %h exp 00000100", r); end
    send_par(8'h07, 1'b1);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h111) begin n_fail++; $display("FAIL par_good_status got %h exp 00000111", r); end
    bus_read(4'hC, r);
    n_checks++;
    if (r !== 32'h07) begin n_fail++; $display("FAIL par_good_data got %h exp 00000007", r); end
    bus_write(4'h4, 32'h100);
    bus_write(4'h0, 32'h1);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL par_w1c got %h exp 00000000", r); end
  endtask
`else
  task automatic test_parity();
    logic [31:0] r;
    bus_write(4'h0, 32'h7);
    bus_read(4'h0, r);
    n_checks++;
    if (r !== 32'h1) begin n_fail++; $display("FAIL ctrl_par_bits got %h exp 00000001", r); end
    bus_write(4'h4, 32'h100);
    bus_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL status_par_bit got %h exp 00000000", r); end
  endtask
`endif

  initial begin
    test_reset();
    test_disabled();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
